icache_refill_engine: RTL and testbench

- AXI3 read-burst refill engine for the instruction cache, placed between the cache miss logic and the AXI3 read channel.
- Parametrised successor to the single-beat refill path. Supports:
  - configurable beat width and line size;
  - full AR/R burst signalling: ARLEN/ARSIZE/ARBURST/RLAST/RRESP;
  - per-beat word index output;
  - error reporting;
  - flush-safe abort with burst draining.
- Accepts one miss at a time. Streams line words to the cache array.

---
 rtl/icache_refill_engine.sv | 171 +++++++++++++++++
 tb/tb_icache_refill_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_engine.sv
// AXI3 burst refill of one I-cache line per miss; `ICACHE_CWF_EN selects critical-word-first WRAP bursts.
// Latency: miss_req -> ARVALID 1 cycle, R handshake -> refill_valid 1 cycle; RREADY held for the whole burst.
module icache_refill_engine #(
  parameter int DATA_LENGTH = 32,
  parameter int LINE_SIZE   = 64,
  parameter int ADDR_WIDTH  = 32,
  localparam int BEATS      = LINE_SIZE / (DATA_LENGTH / 8),
  localparam int IDX_W      = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   miss_req,
  input  logic [ADDR_WIDTH-1:0]  miss_addr,
  output logic                   busy,
  output logic                   refill_valid,
  output logic [DATA_LENGTH-1:0] refill_data,
  output logic [IDX_W-1:0]       refill_idx,
  output logic                   refill_complete,
  output logic                   refill_error,
`ifdef ICACHE_CWF_EN
  output logic                   crit_valid,
`endif
  output logic [ADDR_WIDTH-1:0]  ARADDR,
  output logic [3:0]             ARLEN,
  output logic [2:0]             ARSIZE,
  output logic [1:0]             ARBURST,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  input  logic [DATA_LENGTH-1:0] RDATA,
  input  logic [1:0]             RRESP,
  input  logic                   RLAST,
  input  logic                   RVALID,
  output logic                   RREADY
);

  localparam int OFF_W  = $clog2(LINE_SIZE);
  localparam int BYTE_W = $clog2(DATA_LENGTH / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] beat_cnt;
  logic [IDX_W-1:0] start_idx;
  logic             err_flag;
  logic             abort;

  logic [ADDR_WIDTH-1:0] ar_addr_nxt;
  logic [1:0]            ar_burst_nxt;
  logic [IDX_W-1:0]      start_nxt;
  logic                  unused_addr_bits;

  assign ARLEN  = 4'(BEATS - 1);
  assign ARSIZE = 3'(BYTE_W);

  always_comb begin
    ar_addr_nxt  = '0;
    ar_burst_nxt = 2'b01;
    start_nxt    = '0;
`ifdef ICACHE_CWF_EN
    ar_addr_nxt  = {miss_addr[ADDR_WIDTH-1:BYTE_W], {BYTE_W{1'b0}}};
    ar_burst_nxt = 2'b10;
    start_nxt    = miss_addr[OFF_W-1:BYTE_W];
`else
    ar_addr_nxt  = {miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
`endif
  end

`ifdef ICACHE_CWF_EN
  assign unused_addr_bits = ^miss_addr[BYTE_W-1:0];
`else
  assign unused_addr_bits = ^miss_addr[OFF_W-1:0];
`endif

  logic beat, last_cnt, err_nxt, line_end;
  assign beat     = RVALID && RREADY;
  assign last_cnt = (beat_cnt == IDX_W'(BEATS - 1));
  // A premature or missing RLAST is treated like a bad RRESP.
  assign err_nxt  = err_flag || (RRESP != 2'b00) || (RLAST != last_cnt);
  assign line_end = RLAST || last_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      start_idx       <= '0;
      err_flag        <= 1'b0;
      abort           <= 1'b0;
      busy            <= 1'b0;
      refill_valid    <= 1'b0;
      refill_data     <= '0;
      refill_idx      <= '0;
      refill_complete <= 1'b0;
      refill_error    <= 1'b0;
`ifdef ICACHE_CWF_EN
      crit_valid      <= 1'b0;
`endif
      ARADDR          <= '0;
      ARBURST         <= 2'b00;
      ARVALID         <= 1'b0;
      RREADY          <= 1'b0;
    end else begin
      refill_valid    <= 1'b0;
      refill_complete <= 1'b0;
      refill_error    <= 1'b0;
`ifdef ICACHE_CWF_EN
      crit_valid      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (miss_req && !flush) begin
            state     <= ADDR;
            busy      <= 1'b1;
            ARVALID   <= 1'b1;
            ARADDR    <= ar_addr_nxt;
            ARBURST   <= ar_burst_nxt;
            start_idx <= start_nxt;
            beat_cnt  <= '0;
            err_flag  <= 1'b0;
            abort     <= 1'b0;
          end
        end
        ADDR: begin
          // ARVALID may not drop before the handshake, so a flush is only remembered here.
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            abort   <= 1'b0;
            state   <= (abort || flush) ? DRAIN : DATA;
          end else if (flush) begin
            abort <= 1'b1;
          end
        end
        DATA: begin
          if (beat) begin
            refill_valid <= 1'b1;
            refill_data  <= RDATA;
            refill_idx   <= start_idx + beat_cnt;
            beat_cnt     <= beat_cnt + 1'b1;
            err_flag     <= err_nxt;
`ifdef ICACHE_CWF_EN
            crit_valid   <= (beat_cnt == '0);
`endif
            if (line_end && !flush) begin
              refill_complete <= 1'b1;
              refill_error    <= err_nxt;
            end
            if (RLAST) begin
              state  <= IDLE;
              busy   <= 1'b0;
              RREADY <= 1'b0;
            end else if (last_cnt || flush) begin
              state <= DRAIN;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (RVALID && RLAST) begin
            state  <= IDLE;
            busy   <= 1'b0;
            RREADY <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_engine.sv
// Directed bench for icache_refill_engine (32-bit beats, 64-byte lines); covers CWF when ICACHE_CWF_EN is defined.
module tb_icache_refill_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        miss_req = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        busy, refill_valid, refill_complete, refill_error;
  logic [31:0] refill_data;
  logic [3:0]  refill_idx;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, RREADY;
  logic        ARREADY = 1'b0;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0;
  logic        RLAST = 1'b0;
  logic        RVALID = 1'b0;
`ifdef ICACHE_CWF_EN
  logic        crit_valid;
`endif

  int errors = 0;
  int checks = 0;

  icache_refill_engine #(.DATA_LENGTH(32), .LINE_SIZE(64), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .miss_req(miss_req), .miss_addr(miss_addr),
    .busy(busy), .refill_valid(refill_valid), .refill_data(refill_data), .refill_idx(refill_idx),
    .refill_complete(refill_complete), .refill_error(refill_error),
`ifdef ICACHE_CWF_EN
    .crit_valid(crit_valid),
`endif
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_araddr(input logic [31:0] a);
`ifdef ICACHE_CWF_EN
    return a & ~32'h3;
`else
    return a & ~32'h3F;
`endif
  endfunction

  function automatic int exp_start(input logic [31:0] a);
`ifdef ICACHE_CWF_EN
    return int'((a >> 2) & 32'hF);
`else
    return 0;
`endif
  endfunction

  function automatic logic [1:0] exp_burst();
`ifdef ICACHE_CWF_EN
    return 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  task automatic issue_miss(input logic [31:0] addr, input int ar_wait, input bit flush_addr);
    miss_req  = 1'b1;
    miss_addr = addr;
    tick();
    miss_req = 1'b0;
    chk("arvalid_rise", ARVALID, 1);
    chk("busy_on", busy, 1);
    chk("araddr", ARADDR, exp_araddr(addr));
    chk("arburst", ARBURST, exp_burst());
    chk("arlen", ARLEN, 15);
    chk("arsize", ARSIZE, 2);
    for (int w = 0; w < ar_wait; w++) begin
      flush = flush_addr;
      tick();
      chk("arvalid_hold", ARVALID, 1);
      chk("araddr_hold", ARADDR, exp_araddr(addr));
    end
    flush   = 1'b0;
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    chk("arvalid_drop", ARVALID, 0);
    chk("rready_on", RREADY, 1);
  endtask

  // Slave sends nsend beats (RLAST on the last); the model predicts each refill output.
  task automatic run_r(input int nsend, input int start, input int bad_beat, input int flush_beat,
                       input bit aborted_in, input bit gaps);
    bit aborted;
    bit err;
    bit cmpl;
    int gap;
    aborted = aborted_in;
    err     = 1'b0;
    for (int k = 0; k < nsend; k++) begin
      gap = gaps ? int'($urandom_range(0, 3)) : 0;
      for (int g = 0; g < gap; g++) begin
        RVALID = 1'b0;
        tick();
        chk("gap_no_valid", refill_valid, 0);
      end
      RVALID = 1'b1;
      RDATA  = 32'(k);
      RRESP  = (k == bad_beat) ? 2'b10 : 2'b00;
      RLAST  = (k == nsend - 1);
      flush  = (k == flush_beat);
      chk("rready", RREADY, 1);
      tick();
      err = err || (k == bad_beat) || ((k == nsend - 1) != (k == 15));
      if (aborted) begin
        chk("drain_no_valid", refill_valid, 0);
        chk("drain_no_cmpl", refill_complete, 0);
      end else begin
        cmpl = ((k == nsend - 1) || (k == 15)) && (k != flush_beat);
        chk("refill_valid", refill_valid, 1);
        chk("refill_data", refill_data, 32'(k));
        chk("refill_idx", refill_idx, 32'((start + k) % 16));
        chk("refill_complete", refill_complete, 32'(cmpl));
        if (cmpl) chk("refill_error", refill_error, 32'(err));
`ifdef ICACHE_CWF_EN
        chk("crit_valid", crit_valid, 32'(k == 0));
`endif
      end
      if (k == flush_beat || k == 15) aborted = 1'b1;
      flush = 1'b0;
    end
    RVALID = 1'b0;
    RLAST  = 1'b0;
    RRESP  = 2'b00;
    chk("busy_done", busy, 0);
    chk("rready_done", RREADY, 0);
    tick();
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_refill_valid", refill_valid, 0);
    chk("rst_complete", refill_complete, 0);
    chk("rst_error", refill_error, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_araddr", ARADDR, 0);
    chk("rst_arburst", ARBURST, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_arlen", ARLEN, 15);
    chk("rst_arsize", ARSIZE, 2);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Miss coinciding with flush is dropped; flush alone in IDLE does nothing.
    miss_req  = 1'b1;
    flush     = 1'b1;
    miss_addr = 32'h0000_1008;
    tick();
    chk("miss_flush_busy", busy, 0);
    chk("miss_flush_arvalid", ARVALID, 0);
    miss_req = 1'b0;
    tick();
    chk("idle_flush_busy", busy, 0);
    flush = 1'b0;

    // Clean line.
    issue_miss(32'h0000_1008, 2, 1'b0);
    run_r(16, exp_start(32'h0000_1008), -1, -1, 1'b0, 1'b0);

    // Bad RRESP on beat 5.
    issue_miss(32'h0000_1008, 2, 1'b0);
    run_r(16, exp_start(32'h0000_1008), 5, -1, 1'b0, 1'b0);

    // Flush on beat 6, error flag from previous line must be gone.
    issue_miss(32'h0000_1008, 1, 1'b0);
    run_r(16, exp_start(32'h0000_1008), -1, 6, 1'b0, 1'b0);

    // Flush while the address phase is stalled.
    issue_miss(32'h0000_1008, 3, 1'b1);
    run_r(16, exp_start(32'h0000_1008), -1, -1, 1'b1, 1'b0);

    // Early RLAST on beat 9.
    issue_miss(32'h0000_1040, 0, 1'b0);
    run_r(10, exp_start(32'h0000_1040), -1, -1, 1'b0, 1'b0);

    // RVALID gaps, clean line.
    issue_miss(32'h0000_10C4, 1, 1'b0);
    run_r(16, exp_start(32'h0000_10C4), -1, -1, 1'b0, 1'b1);

    // RLAST missing on beat 15: complete with error, then drain two extra beats.
    issue_miss(32'h0000_1008, 0, 1'b0);
    run_r(18, exp_start(32'h0000_1008), -1, -1, 1'b0, 1'b0);

`ifdef ICACHE_CWF_EN
    issue_miss(32'h0000_2034, 1, 1'b0);
    chk("cwf_start", 32'(exp_start(32'h0000_2034)), 13);
    run_r(16, 13, -1, -1, 1'b0, 1'b1);
`endif

    // Asynchronous reset in the middle of a burst.
    issue_miss(32'h0000_1008, 0, 1'b0);
    RVALID = 1'b1;
    RDATA  = 32'h55;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rready", RREADY, 0);
    chk("mid_rst_valid", refill_valid, 0);
    RVALID = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
